// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Clock cycles occupied by one complete serial frame.
    function automatic int unsigned frame_cycles(
        input int unsigned data_bits,
        input int unsigned parity,
        input int unsigned stop_bits,
        input int unsigned clks_per_bit
    );
        return (32'd1 + data_bits + ((parity != PAR_NONE) ? 32'd1 : 32'd0) + stop_bits)
               * clks_per_bit;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty/level.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // Pushes are gated by the registered full flag, pops by the registered empty flag.
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == LVL_W'(0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: core writes are queued, then serialised onto tx.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY       = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          clr_overflow,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;
    logic                 pop_c;
    logic                 bit_end_c;
    logic                 par_load_c;
    logic [DATA_BITS-1:0] fifo_dout;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop_c),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign par_load_c = (PARITY == PAR_ODD) ? ~(^fifo_dout) : (^fifo_dout);
    assign bit_end_c  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // Next-state logic; tx is derived from the current state so it trails state by one cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop_c   = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_dout;
                    par_d   = par_load_c;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_end_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end_c) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_PAR: begin
                tx_d = par_q;
                if (bit_end_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end_c) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (!empty) begin
                            pop_c   = 1'b1;
                            shift_d = fifo_dout;
                            par_d   = par_load_c;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Sticky drop flag: a drop in the same cycle as a clear keeps it set.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: frame vectors on three parity/stop configurations plus FIFO corner sequences.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int unsigned CPB = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_overflow;
    int         sel;

    logic       wr_en_m, wr_en_e, wr_en_o;
    logic       full_m, full_e, full_o;
    logic       empty_m, empty_e, empty_o;
    logic [4:0] level_m, level_e, level_o;
    logic       ovf_m, ovf_e, ovf_o;
    logic       busy_m, busy_e, busy_o;
    logic       tx_m, tx_e, tx_o;

    logic       tx_s, busy_s, empty_s;
    logic [4:0] level_s;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    assign wr_en_m = wr_en && (sel == 0);
    assign wr_en_e = wr_en && (sel == 1);
    assign wr_en_o = wr_en && (sel == 2);

    uart_tx_fifo dut (
        .clock(clock), .reset(reset), .wr_en(wr_en_m), .wr_data(wr_data),
        .clr_overflow(clr_overflow), .full(full_m), .empty(empty_m), .level(level_m),
        .overflow(ovf_m), .busy(busy_m), .tx(tx_m)
    );

    uart_tx_fifo #(.PARITY(1)) dut_e (
        .clock(clock), .reset(reset), .wr_en(wr_en_e), .wr_data(wr_data),
        .clr_overflow(clr_overflow), .full(full_e), .empty(empty_e), .level(level_e),
        .overflow(ovf_e), .busy(busy_e), .tx(tx_e)
    );

    uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) dut_o (
        .clock(clock), .reset(reset), .wr_en(wr_en_o), .wr_data(wr_data),
        .clr_overflow(clr_overflow), .full(full_o), .empty(empty_o), .level(level_o),
        .overflow(ovf_o), .busy(busy_o), .tx(tx_o)
    );

    always_comb begin
        case (sel)
            1:       begin tx_s = tx_e; busy_s = busy_e; empty_s = empty_e; level_s = level_e; end
            2:       begin tx_s = tx_o; busy_s = busy_o; empty_s = empty_o; level_s = level_o; end
            default: begin tx_s = tx_m; busy_s = busy_m; empty_s = empty_m; level_s = level_m; end
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          nbits;
        logic [11:0] frame;
    } vec_t;

    vec_t vecs [10];

    // Single write into an idle DUT; checks latency, full waveform and busy width.
    task automatic run_vec(input vec_t v);
        logic [47:0] cap;
        logic [47:0] exp;
        int          len;
        int          busy_cnt;
        len = v.nbits * CPB;
        cap = '0;
        exp = '0;
        for (int k = 0; k < len; k++) exp[k] = v.frame[k / CPB];
        sel     = v.sel;
        wr_data = v.data;
        wr_en   = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        check("vec_level_after_write", 64'(level_s), 64'd1);
        @(negedge clock);
        check("vec_tx_before_start", 64'(tx_s), 64'd1);
        check("vec_busy_at_pop", 64'(busy_s), 64'd1);
        check("vec_empty_after_pop", 64'(empty_s), 64'd1);
        busy_cnt = 1;
        for (int k = 0; k < len; k++) begin
            @(negedge clock);
            cap[k] = tx_s;
            if (busy_s) busy_cnt++;
        end
        check("vec_frame", 64'(cap), 64'(exp));
        check("vec_busy_cycles", 64'(busy_cnt), 64'(len));
        check("vec_busy_end", 64'(busy_s), 64'd0);
        @(negedge clock);
        check("vec_tx_idle", 64'(tx_s), 64'd1);
    endtask

    // Decode one 8N1 frame from the main DUT, sampling mid-bit.
    task automatic rx_byte(output logic [7:0] b, output bit ok);
        int t;
        ok = 1'b0;
        b  = '0;
        t  = 0;
        while (tx_m !== 1'b0 && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (tx_m !== 1'b0) return;
        repeat (2) @(negedge clock);
        if (tx_m !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            b[i] = tx_m;
        end
        repeat (CPB) @(negedge clock);
        ok = (tx_m === 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] cap3 [3];
        logic [11:0] fr3  [3];
        logic [47:0] e3;
        int          busy_cnt;
        int          low_cnt;
        logic [4:0]  lv0, lv38, lv39, lv79;
        logic        em79;

        vecs[0] = '{0, 8'h41, 10, 12'h282};
        vecs[1] = '{0, 8'h00, 10, 12'h200};
        vecs[2] = '{0, 8'hFF, 10, 12'h3FE};
        vecs[3] = '{0, 8'hA5, 10, 12'h34A};
        vecs[4] = '{1, 8'h41, 11, 12'h482};
        vecs[5] = '{1, 8'h07, 11, 12'h60E};
        vecs[6] = '{1, 8'h00, 11, 12'h400};
        vecs[7] = '{2, 8'h41, 12, 12'hE82};
        vecs[8] = '{2, 8'h00, 12, 12'hE00};
        vecs[9] = '{2, 8'h80, 12, 12'hD00};

        sel = 0; reset = 1'b1; wr_en = 1'b0; wr_data = '0; clr_overflow = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_tx", 64'(tx_m), 64'd1);
        check("rst_busy", 64'(busy_m), 64'd0);
        check("rst_empty", 64'(empty_m), 64'd1);
        check("rst_full", 64'(full_m), 64'd0);
        check("rst_level", 64'(level_m), 64'd0);
        check("rst_overflow", 64'(ovf_m), 64'd0);
        @(negedge clock);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);
        sel = 0;
        repeat (2) @(negedge clock);

        // Three consecutive writes: gap-free frames and level evolution.
        fr3[0] = 12'h2AA; fr3[1] = 12'h354; fr3[2] = 12'h21A;
        wr_en = 1'b1; wr_data = 8'h55;
        @(negedge clock); wr_data = 8'hAA;
        @(negedge clock); wr_data = 8'h0D;
        check("b2b_busy_start", 64'(busy_m), 64'd1);
        @(negedge clock); wr_en = 1'b0;
        busy_cnt = 1;
        lv0 = '0; lv38 = '0; lv39 = '0; lv79 = '0; em79 = 1'b0;
        for (int f = 0; f < 3; f++) cap3[f] = '0;
        for (int k = 0; k < 120; k++) begin
            if (k > 0) @(negedge clock);
            cap3[k / 40][k % 40] = tx_m;
            if (busy_m) busy_cnt++;
            if (k == 0)  lv0 = level_m;
            if (k == 38) lv38 = level_m;
            if (k == 39) lv39 = level_m;
            if (k == 79) begin lv79 = level_m; em79 = empty_m; end
        end
        for (int f = 0; f < 3; f++) begin
            e3 = '0;
            for (int k = 0; k < 40; k++) e3[k] = fr3[f][k / CPB];
            check("b2b_frame", 64'(cap3[f]), 64'(e3));
        end
        check("b2b_busy_cycles", 64'(busy_cnt), 64'd120);
        check("b2b_level_peak", 64'(lv0), 64'd2);
        check("b2b_level_hold", 64'(lv38), 64'd2);
        check("b2b_level_one", 64'(lv39), 64'd1);
        check("b2b_level_zero", 64'(lv79), 64'd0);
        check("b2b_empty", 64'(em79), 64'd1);
        check("b2b_idle", 64'(busy_m), 64'd0);
        repeat (3) @(negedge clock);

        // Eighteen writes: 0x00 to shifter, 16 queued, 0x11 dropped.
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    wr_en = 1'b1; wr_data = 8'(i);
                    @(negedge clock);
                    if (i == 15) check("ovf_not_full_15", 64'(full_m), 64'd0);
                    if (i == 16) begin
                        check("ovf_full_17", 64'(full_m), 64'd1);
                        check("ovf_clear_before_drop", 64'(ovf_m), 64'd0);
                    end
                end
                wr_en = 1'b0;
                check("ovf_set", 64'(ovf_m), 64'd1);
                check("ovf_level", 64'(level_m), 64'd16);
            end
            begin
                logic [7:0] b;
                bit         ok;
                for (int j = 0; j < 17; j++) begin
                    rx_byte(b, ok);
                    check("ovf_rx_ok", 64'(ok), 64'd1);
                    check("ovf_rx_byte", 64'(b), 64'(j));
                end
            end
        join
        low_cnt = 0;
        repeat (60) begin
            @(negedge clock);
            if (tx_m !== 1'b1) low_cnt++;
        end
        check("ovf_no_extra_frame", 64'(low_cnt), 64'd0);
        check("ovf_drain_empty", 64'(empty_m), 64'd1);
        check("ovf_drain_idle", 64'(busy_m), 64'd0);
        check("ovf_sticky", 64'(ovf_m), 64'd1);

        // Refill, then clear races a drop, then clear alone.
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'h00;
            @(negedge clock);
        end
        check("clr_full", 64'(full_m), 64'd1);
        clr_overflow = 1'b1;
        @(negedge clock);
        check("clr_vs_drop", 64'(ovf_m), 64'd1);
        wr_en = 1'b0;
        @(negedge clock);
        clr_overflow = 1'b0;
        check("clr_alone", 64'(ovf_m), 64'd0);
        check("mid_tx_low", 64'(tx_m), 64'd0);
        check("mid_busy", 64'(busy_m), 64'd1);
        check("mid_level", 64'(level_m), 64'd16);

        // Reset in the middle of the data bits.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_tx", 64'(tx_m), 64'd1);
        check("midrst_busy", 64'(busy_m), 64'd0);
        check("midrst_empty", 64'(empty_m), 64'd1);
        check("midrst_level", 64'(level_m), 64'd0);
        check("midrst_full", 64'(full_m), 64'd0);
        low_cnt = 0;
        repeat (80) begin
            @(negedge clock);
            if (tx_m !== 1'b1 || busy_m !== 1'b0) low_cnt++;
        end
        check("midrst_quiet", 64'(low_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
